// File: rtl/fifo_arbiter.sv
// Round-robin write arbiter and occupancy tracker for a register-based FIFO chain, with per-producer burst lock.
// Latency: grant and strobes are combinational in the request cycle; count/full/empty/locked update one cycle after the edge.
// Backpressure: no producer is granted while full and pops are suppressed while empty; a full FIFO does not release a lock.
module fifo_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int N_REQ = 4
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  input  logic                       rd_req,
  output logic [N_REQ-1:0]           gnt,
  output logic [WIDTH-1:0]           fifo_si,
  output logic                       fifo_shift_in,
  output logic                       fifo_shift_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       locked
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic          win_vld;
  logic [IW-1:0] win_idx;
  logic          sel_vld;
  logic [IW-1:0] sel_idx;
  logic          pop;
  logic [CW-1:0] cnt_nxt;

  // Round-robin search: iterate from the farthest offset down so the nearest requester after ptr wins.
  always_comb begin
    int            k;
    logic [IW-1:0] kk;
    win_vld = 1'b0;
    win_idx = '0;
    k       = 0;
    kk      = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      k  = (int'(ptr) + i) % N_REQ;
      kk = IW'(k);
      if (req[kk]) begin
        win_vld = 1'b1;
        win_idx = kk;
      end
    end
  end

  // Choose who may push this cycle: the round-robin winner when idle, only the owner when locked.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = owner;
    if (!res && !full) begin
      if (state == IDLE) begin
        sel_vld = win_vld;
        sel_idx = win_idx;
      end else begin
        sel_vld = req[owner];
        sel_idx = owner;
      end
    end
  end

  // Expand the selection into the one-hot grant and steer that producer's word to the chain input.
  always_comb begin
    gnt     = '0;
    fifo_si = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_vld && (sel_idx == IW'(i))) begin
        gnt[i]  = 1'b1;
        fifo_si = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  assign fifo_shift_in  = sel_vld;
  assign pop            = !res && rd_req && !empty;
  assign fifo_shift_out = pop;

  // Next occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    cnt_nxt = count;
    if (sel_vld && !pop) begin
      cnt_nxt = count + CW'(1);
    end else if (!sel_vld && pop) begin
      cnt_nxt = count - CW'(1);
    end
  end

  // Occupancy, round-robin pointer and burst-lock state machine with registered status outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      locked <= 1'b0;
      state  <= IDLE;
      ptr    <= IW'(N_REQ-1);
      owner  <= '0;
    end else begin
      count <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
      if (sel_vld) begin
        ptr <= sel_idx;
      end
      case (state)
        IDLE: begin
          if (sel_vld && lock[win_idx]) begin
            state  <= LOCKED;
            owner  <= win_idx;
            locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (!lock[owner]) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_arbiter.sv
module tb_fifo_arbiter;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int N_REQ = 4;
  localparam int CW    = 4;
  localparam logic [15:0] WDATA = 16'h5C38;

  logic                   clk = 1'b0;
  logic                   res = 1'b1;
  logic [N_REQ-1:0]       req = '0;
  logic [N_REQ-1:0]       lock = '0;
  logic [N_REQ*WIDTH-1:0] wdata = WDATA;
  logic                   rd_req = 1'b0;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       fifo_si;
  logic                   fifo_shift_in;
  logic                   fifo_shift_out;
  logic [CW-1:0]          count;
  logic                   full;
  logic                   empty;
  logic                   locked;

  fifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ)) dut (
    .clk(clk), .res(res), .req(req), .lock(lock), .wdata(wdata), .rd_req(rd_req),
    .gnt(gnt), .fifo_si(fifo_si), .fifo_shift_in(fifo_shift_in), .fifo_shift_out(fifo_shift_out),
    .count(count), .full(full), .empty(empty), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic       so;
    logic [3:0] cnt;
    logic       locked;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   vec_id = 0;

  // Producer words: p0=8, p1=3, p2=C, p3=5.
  function automatic logic [3:0] data_of(input logic [3:0] g);
    case (g)
      4'b0001: return 4'h8;
      4'b0010: return 4'h3;
      4'b0100: return 4'hC;
      4'b1000: return 4'h5;
      default: return 4'h0;
    endcase
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %0h, want %0h", id, nm, act, want);
    end
  endtask

  // Monitor: mid-cycle, pop the expectation for the current cycle and compare every output.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("gnt",       e.id, 32'(gnt),            32'(e.gnt));
      chk("shift_in",  e.id, 32'(fifo_shift_in),  32'(|e.gnt));
      chk("fifo_si",   e.id, 32'(fifo_si),        32'(data_of(e.gnt)));
      chk("shift_out", e.id, 32'(fifo_shift_out), 32'(e.so));
      chk("count",     e.id, 32'(count),          32'(e.cnt));
      chk("full",      e.id, 32'(full),           32'(e.cnt == 4'd8));
      chk("empty",     e.id, 32'(empty),          32'(e.cnt == 4'd0));
      chk("locked",    e.id, 32'(locked),         32'(e.locked));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] lk, input logic rd,
                      input logic [3:0] eg, input logic eso, input int ec, input logic el);
    exp_t e;
    res    = r;
    req    = rq;
    lock   = lk;
    rd_req = rd;
    e.gnt    = eg;
    e.so     = eso;
    e.cnt    = 4'(ec);
    e.locked = el;
    e.id     = vec_id;
    vec_id++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset holds strobes low regardless of inputs; status is at reset values.
    step(1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 0, 0);
    step(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0);

    // Fairness with a concurrent reader.
    step(0, 4'b1111, 4'b0000, 1, 4'b0001, 0, 0, 0);
    step(0, 4'b1111, 4'b0000, 1, 4'b0010, 1, 1, 0);
    step(0, 4'b1111, 4'b0000, 1, 4'b0100, 1, 1, 0);
    step(0, 4'b1111, 4'b0000, 1, 4'b1000, 1, 1, 0);
    step(0, 4'b1111, 4'b0000, 1, 4'b0001, 1, 1, 0);
    step(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 0);

    // Fill to full and keep requesting: exactly 8 pushes.
    for (int i = 0; i < 10; i++)
      step(0, 4'b0001, 4'b0000, 0, (i < 8) ? 4'b0001 : 4'b0000, 0, (i < 8) ? i : 8, 0);
    for (int i = 0; i < 8; i++)
      step(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8 - i, 0);

    // Reads while empty are ignored.
    for (int i = 0; i < 3; i++)
      step(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0);

    // Simultaneous push/pop at count 3, then at count 8 (pop only).
    for (int i = 0; i < 3; i++)
      step(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, i, 0);
    step(0, 4'b0001, 4'b0000, 1, 4'b0001, 1, 3, 0);
    step(0, 4'b0001, 4'b0000, 1, 4'b0001, 1, 3, 0);
    for (int i = 3; i < 8; i++)
      step(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, i, 0);
    step(0, 4'b0001, 4'b0000, 1, 4'b0000, 1, 8, 0);
    step(0, 4'b0001, 4'b0000, 0, 4'b0001, 0, 7, 0);
    for (int i = 0; i < 8; i++)
      step(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 8 - i, 0);
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0);

    // Burst lock by producer 2, idle owner blocks others, release hands over to producer 3.
    step(0, 4'b0100, 4'b0100, 0, 4'b0100, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 4'b1111, 4'b0100, 0, 4'b0100, 0, 1 + i, 1);
    step(0, 4'b1011, 4'b0100, 0, 4'b0000, 0, 5, 1);
    step(0, 4'b1111, 4'b0000, 0, 4'b0100, 0, 5, 1);
    step(0, 4'b1111, 4'b0000, 0, 4'b1000, 0, 6, 0);

    // Reset mid-burst with count 5.
    step(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 7, 0);
    step(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 6, 0);
    step(0, 4'b0001, 4'b0001, 1, 4'b0001, 1, 5, 0);
    step(1, 4'b1111, 4'b1111, 1, 4'b0000, 0, 5, 1);
    step(0, 4'b1111, 4'b0000, 0, 4'b0001, 0, 0, 0);
    step(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 1, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
